mb_ram_responder: RTL and testbench

- Bus responder (slave) on the motherboard 7 MHz 68000 bus. Serves trapdoor/slow RAM space 0xC00000-0xD7FFFF for any bus master (68000, DMA-capable expansion).
- Decodes AS_7/UDS/LDS/RW, drives the RAM strobes, and returns DTACK_7 after a programmable number of wait states.
- The counterpart of the accelerator-side initiator: that block asserts AS_7 and waits on DTACK_7; this block consumes AS_7 and generates DTACK_7.

---
 rtl/mb_ram_responder.sv | 202 ++++++++++++++++++++
 tb/tb_mb_ram_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mb_ram_responder.sv
// mb_ram_responder: motherboard 7 MHz bus responder for trapdoor/slow RAM.
// Decodes AS_7/UDS/LDS/RW, drives the RAM strobes, and returns DTACK_7
// after WAIT_STATES wait states. DTACK_7 and BERR_7 are open-drain outputs.
// Optional: define MB_RAM_BERR_TIMEOUT_EN for a data-strobe timeout that
// signals BERR_7.
module mb_ram_responder #(
  parameter int unsigned WAIT_STATES    = 1,
  parameter logic [4:0]  RANGE_LO       = 5'h18,
  parameter logic [4:0]  RANGE_HI       = 5'h1A,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        CLK_7,
  input  logic        RESET,
  input  logic        AS_7,
  input  logic        UDS,
  input  logic        LDS,
  input  logic        RW,
  input  logic [23:19] ADDRESS,
  output logic        DTACK_7,
  output logic        BERR_7,
  output logic        RAM_CE_n,
  output logic        RAM_OE_n,
  output logic        RAM_WR_n,
  output logic        RAM_LB_n,
  output logic        RAM_UB_n,
  output logic        RAM_ACTIVE
);

  // Reject parameter values the counters cannot represent.
  if (WAIT_STATES > 7) begin : g_bad_wait_states
    $error("mb_ram_responder: WAIT_STATES must be in 0..7");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
    $error("mb_ram_responder: TIMEOUT_CYCLES must be in 1..256");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_WAIT,
    S_ACK
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] wait_q,  wait_d;
  logic       armed_q, armed_d;
  logic       ce_q,    ce_d;
  logic       oe_q,    oe_d;
  logic       wr_q,    wr_d;
  logic       lb_q,    lb_d;
  logic       ub_q,    ub_d;
  logic       dtack_q, dtack_d;
  logic       active_q, active_d;

`ifdef MB_RAM_BERR_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] to_q, to_d;
  logic       berr_q, berr_d;
`endif

  logic hit;
  logic ds;
  logic release_cyc;

  assign hit         = !AS_7 && (ADDRESS >= RANGE_LO) && (ADDRESS <= RANGE_HI);
  assign ds          = !UDS || !LDS;
  // Any AS_7 negation outside IDLE ends the cycle (normal end or abort).
  assign release_cyc = AS_7 && (state_q != S_IDLE);

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    ce_d     = ce_q;
    oe_d     = oe_q;
    wr_d     = wr_q;
    lb_d     = lb_q;
    ub_d     = ub_q;
    dtack_d  = dtack_q;
    active_d = active_q;
    // A new cycle is only accepted once AS_7 has been seen high.
    armed_d  = AS_7 ? 1'b1 : armed_q;
`ifdef MB_RAM_BERR_TIMEOUT_EN
    to_d     = to_q;
    berr_d   = berr_q;
`endif

    if (release_cyc) begin
      state_d  = S_IDLE;
      wait_d   = '0;
      ce_d     = 1'b1;
      oe_d     = 1'b1;
      wr_d     = 1'b1;
      lb_d     = 1'b1;
      ub_d     = 1'b1;
      dtack_d  = 1'b0;
      active_d = 1'b0;
`ifdef MB_RAM_BERR_TIMEOUT_EN
      to_d     = '0;
      berr_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hit && armed_q) begin
            state_d  = S_SELECT;
            ce_d     = 1'b0;
            active_d = 1'b1;
            armed_d  = 1'b0;
          end
        end
        S_SELECT: begin
          if (ds) begin
            // Byte lanes and direction are latched once here.
            lb_d    = LDS;
            ub_d    = UDS;
            oe_d    = !RW;
            wr_d    = RW;
            wait_d  = 3'(WAIT_STATES);
            state_d = S_WAIT;
`ifdef MB_RAM_BERR_TIMEOUT_EN
            to_d    = '0;
`endif
          end
`ifdef MB_RAM_BERR_TIMEOUT_EN
          else if (to_q == TO_LAST) begin
            berr_d  = 1'b1;
            to_d    = '0;
            state_d = S_ACK;
          end else begin
            to_d = to_q + 8'd1;
          end
`endif
        end
        S_WAIT: begin
          if (wait_q == 3'd0) begin
            dtack_d = 1'b1;
            state_d = S_ACK;
          end else begin
            wait_d = wait_q - 3'd1;
          end
        end
        S_ACK: begin
          // Hold everything until AS_7 negation (handled by release_cyc).
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK_7 or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      armed_q  <= 1'b0;
      ce_q     <= 1'b1;
      oe_q     <= 1'b1;
      wr_q     <= 1'b1;
      lb_q     <= 1'b1;
      ub_q     <= 1'b1;
      dtack_q  <= 1'b0;
      active_q <= 1'b0;
`ifdef MB_RAM_BERR_TIMEOUT_EN
      to_q     <= '0;
      berr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      armed_q  <= armed_d;
      ce_q     <= ce_d;
      oe_q     <= oe_d;
      wr_q     <= wr_d;
      lb_q     <= lb_d;
      ub_q     <= ub_d;
      dtack_q  <= dtack_d;
      active_q <= active_d;
`ifdef MB_RAM_BERR_TIMEOUT_EN
      to_q     <= to_d;
      berr_q   <= berr_d;
`endif
    end
  end

  assign RAM_CE_n   = ce_q;
  assign RAM_OE_n   = oe_q;
  assign RAM_WR_n   = wr_q;
  assign RAM_LB_n   = lb_q;
  assign RAM_UB_n   = ub_q;
  assign RAM_ACTIVE = active_q;
  assign DTACK_7    = dtack_q ? 1'b0 : 1'bz;

`ifdef MB_RAM_BERR_TIMEOUT_EN
  assign BERR_7 = berr_q ? 1'b0 : 1'bz;
`else
  assign BERR_7 = 1'bz;
`endif

endmodule

// File: tb/tb_mb_ram_responder.sv
// Directed bench for mb_ram_responder: three instances (WAIT_STATES 0/1/5)
// share the bus inputs; open-drain lines are resolved through pull-ups so a
// released line reads 1. Output word order: {CE,OE,WR,LB,UB,DTACK,ACTIVE}.
module tb_mb_ram_responder;

  logic       clk;
  logic       rst_n;
  logic       as_n;
  logic       uds;
  logic       lds;
  logic       rw;
  logic [4:0] addr;

  wire [2:0] ce, oe, wr, lb, ub, act;
  wire dt_0, dt_1, dt_2;
  wire be_0, be_1, be_2;
  pullup (dt_0);
  pullup (dt_1);
  pullup (dt_2);
  pullup (be_0);
  pullup (be_1);
  pullup (be_2);

  int unsigned n_cmp;
  int unsigned n_bad;

  localparam logic [6:0] IDLE_O  = 7'b1111110;
  localparam logic [6:0] SEL_O   = 7'b0111111;
  localparam logic [6:0] RD_O    = 7'b0010011;
  localparam logic [6:0] RD_ACK  = 7'b0010001;
  localparam logic [6:0] WRB_O   = 7'b0100111;
  localparam logic [6:0] WRB_ACK = 7'b0100101;

  mb_ram_responder #(.WAIT_STATES(0)) dut0 (
    .CLK_7(clk), .RESET(rst_n), .AS_7(as_n), .UDS(uds), .LDS(lds), .RW(rw),
    .ADDRESS(addr), .DTACK_7(dt_0), .BERR_7(be_0), .RAM_CE_n(ce[0]),
    .RAM_OE_n(oe[0]), .RAM_WR_n(wr[0]), .RAM_LB_n(lb[0]), .RAM_UB_n(ub[0]),
    .RAM_ACTIVE(act[0])
  );

  mb_ram_responder #(.WAIT_STATES(1)) dut1 (
    .CLK_7(clk), .RESET(rst_n), .AS_7(as_n), .UDS(uds), .LDS(lds), .RW(rw),
    .ADDRESS(addr), .DTACK_7(dt_1), .BERR_7(be_1), .RAM_CE_n(ce[1]),
    .RAM_OE_n(oe[1]), .RAM_WR_n(wr[1]), .RAM_LB_n(lb[1]), .RAM_UB_n(ub[1]),
    .RAM_ACTIVE(act[1])
  );

  mb_ram_responder #(.WAIT_STATES(5)) dut5 (
    .CLK_7(clk), .RESET(rst_n), .AS_7(as_n), .UDS(uds), .LDS(lds), .RW(rw),
    .ADDRESS(addr), .DTACK_7(dt_2), .BERR_7(be_2), .RAM_CE_n(ce[2]),
    .RAM_OE_n(oe[2]), .RAM_WR_n(wr[2]), .RAM_LB_n(lb[2]), .RAM_UB_n(ub[2]),
    .RAM_ACTIVE(act[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       as_n;
    logic       uds;
    logic       lds;
    logic       rw;
    logic [4:0] addr;
    int         sel;
    logic [6:0] exp;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic a, logic u, logic l, logic r,
                              logic [4:0] ad, int s, logic [6:0] e);
    vec_t v;
    v.as_n = a; v.uds = u; v.lds = l; v.rw = r;
    v.addr = ad; v.sel = s; v.exp = e;
    return v;
  endfunction

  function automatic logic [6:0] outs(int s);
    case (s)
      0:       return {ce[0], oe[0], wr[0], lb[0], ub[0], dt_0, act[0]};
      1:       return {ce[1], oe[1], wr[1], lb[1], ub[1], dt_1, act[1]};
      default: return {ce[2], oe[2], wr[2], lb[2], ub[2], dt_2, act[2]};
    endcase
  endfunction

  function automatic logic berr_line(int s);
    case (s)
      0:       return be_0;
      1:       return be_1;
      default: return be_2;
    endcase
  endfunction

  task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic drive(input logic a, input logic u, input logic l,
                       input logic r, input logic [4:0] ad);
    as_n = a; uds = u; lds = l; rw = r; addr = ad;
  endtask

  task automatic edge_tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 5'h00);

    // Reset state
    edge_tick();
    edge_tick();
    chk("reset_ws0", outs(0), IDLE_O);
    chk("reset_ws1", outs(1), IDLE_O);
    chk("reset_ws5", outs(2), IDLE_O);
    rst_n = 1'b1;

    // Read, WAIT_STATES=1
    vt.push_back(mk(1, 1, 1, 1, 5'h18, 1, IDLE_O));
    vt.push_back(mk(0, 0, 0, 1, 5'h18, 1, SEL_O));
    vt.push_back(mk(0, 0, 0, 1, 5'h18, 1, RD_O));
    vt.push_back(mk(0, 0, 0, 1, 5'h18, 1, RD_O));
    vt.push_back(mk(0, 0, 0, 1, 5'h18, 1, RD_ACK));
    vt.push_back(mk(0, 0, 0, 1, 5'h18, 1, RD_ACK));
    vt.push_back(mk(1, 1, 1, 1, 5'h18, 1, IDLE_O));
    // Lower-byte write, WAIT_STATES=0; WR_n held until AS_7 negates
    vt.push_back(mk(0, 1, 0, 0, 5'h1A, 0, SEL_O));
    vt.push_back(mk(0, 1, 0, 0, 5'h1A, 0, WRB_O));
    vt.push_back(mk(0, 1, 0, 0, 5'h1A, 0, WRB_ACK));
    vt.push_back(mk(0, 1, 1, 0, 5'h1A, 0, WRB_ACK));
    vt.push_back(mk(1, 1, 1, 0, 5'h1A, 0, IDLE_O));
    // Out of range just below and just above
    vt.push_back(mk(0, 0, 0, 1, 5'h17, 1, IDLE_O));
    vt.push_back(mk(0, 0, 0, 1, 5'h17, 1, IDLE_O));
    vt.push_back(mk(1, 1, 1, 1, 5'h17, 1, IDLE_O));
    vt.push_back(mk(0, 0, 0, 1, 5'h1B, 1, IDLE_O));
    vt.push_back(mk(0, 0, 0, 1, 5'h1B, 1, IDLE_O));
    vt.push_back(mk(1, 1, 1, 1, 5'h1B, 1, IDLE_O));
    // Abort in WAIT, WAIT_STATES=5, then a normal cycle
    vt.push_back(mk(0, 0, 0, 1, 5'h19, 2, SEL_O));
    vt.push_back(mk(0, 0, 0, 1, 5'h19, 2, RD_O));
    vt.push_back(mk(0, 0, 0, 1, 5'h19, 2, RD_O));
    vt.push_back(mk(0, 0, 0, 1, 5'h19, 2, RD_O));
    vt.push_back(mk(1, 1, 1, 1, 5'h19, 2, IDLE_O));
    vt.push_back(mk(1, 1, 1, 1, 5'h19, 2, IDLE_O));
    vt.push_back(mk(0, 0, 0, 1, 5'h18, 2, SEL_O));
    for (int k = 0; k < 6; k++) begin
      vt.push_back(mk(0, 0, 0, 1, 5'h18, 2, RD_O));
    end
    vt.push_back(mk(0, 0, 0, 1, 5'h18, 2, RD_ACK));
    vt.push_back(mk(1, 1, 1, 1, 5'h18, 2, IDLE_O));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].as_n, vt[i].uds, vt[i].lds, vt[i].rw, vt[i].addr);
      edge_tick();
      chk($sformatf("vec%0d", i), outs(vt[i].sel), vt[i].exp);
      chk($sformatf("vec%0d_berr", i), {6'b0, berr_line(vt[i].sel)}, 7'd1);
    end

    // Reset pulse during ACK, then AS_7 held low must not retrigger
    drive(0, 0, 0, 1, 5'h18);
    for (int k = 0; k < 4; k++) edge_tick();
    chk("pre_rst_ack", outs(1), RD_ACK);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async_ws1", outs(1), IDLE_O);
    chk("rst_async_ws0", outs(0), IDLE_O);
    edge_tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      edge_tick();
      chk($sformatf("no_retrigger%0d", k), outs(1), IDLE_O);
    end
    drive(1, 1, 1, 1, 5'h18);
    edge_tick();
    chk("rearm_idle", outs(1), IDLE_O);
    drive(0, 0, 0, 1, 5'h18);
    edge_tick();
    chk("rearm_select", outs(1), SEL_O);
    drive(1, 1, 1, 1, 5'h18);
    edge_tick();
    chk("rearm_release", outs(1), IDLE_O);

`ifdef MB_RAM_BERR_TIMEOUT_EN
    // DS never arrives: BERR_7 at edge 64 after SELECT entry
    drive(0, 1, 1, 1, 5'h18);
    edge_tick();
    chk("to_entry", outs(1), SEL_O);
    for (int k = 1; k < 64; k++) edge_tick();
    chk("to_edge63_berr", {6'b0, be_1}, 7'd1);
    edge_tick();
    chk("to_edge64_berr", {6'b0, be_1}, 7'd0);
    chk("to_edge64_outs", outs(1), SEL_O);
    edge_tick();
    chk("to_hold_berr", {6'b0, be_1}, 7'd0);
    drive(1, 1, 1, 1, 5'h18);
    edge_tick();
    chk("to_release_berr", {6'b0, be_1}, 7'd1);
    chk("to_release_outs", outs(1), IDLE_O);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
